// File: rtl/fpalu_pkg.sv
// Shared types and constants for the FP ALU host sequencer.
package fpalu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RECV      = 3'd4,
    ST_HOLD      = 3'd5
  } fpalu_state_e;

  localparam logic [1:0] FPALU_OP_ADD = 2'b00;
  localparam logic [1:0] FPALU_OP_SUB = 2'b01;

  localparam int FPALU_OPERAND_BYTES = 4;
  localparam int FPALU_RESULT_BYTES  = 4;
  localparam int FPALU_TX_BYTES      = 8;

endpackage

// File: rtl/fpalu_res_deser.sv
// Result collector: packs ALU result bytes LSB-first into one word.
module fpalu_res_deser
  import fpalu_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            load,
  input  logic [7:0]                      din,
  output logic [8*FPALU_RESULT_BYTES-1:0] word,
  output logic [2:0]                      cnt,
  output logic                            full
);

  assign full = (cnt == 3'(FPALU_RESULT_BYTES));

  // Loads beyond a full word are dropped so a late done cannot corrupt the result.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (load && !full) begin
      word[{cnt[1:0], 3'b000} +: 8] <= din;
      cnt                           <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/fpalu_host_seq.sv
// Host sequencer for the byte-serial FP ALU: command in, 8 operand bytes out, 4 result bytes in.
// Optional WAIT_DONE timeout enabled by defining FPALU_SEQ_TIMEOUT_EN.
module fpalu_host_seq
  import fpalu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        alu_start,
  output logic [1:0]  alu_opcode,
  output logic [7:0]  alu_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_done
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge.

  localparam logic [2:0] LAST_TX = 3'(FPALU_TX_BYTES - 1);
  localparam logic [2:0] LAST_RX = 3'(FPALU_RESULT_BYTES - 1);

  fpalu_state_e state, state_nxt;

  logic [8*FPALU_TX_BYTES-1:0] tx_word;
  logic [2:0] byte_cnt, byte_nxt;
  logic [2:0] rx_cnt;
  logic       rx_full;
  logic       accept, deser_clr, deser_load, timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_START;
      ST_START:     state_nxt = ST_SEND;
      ST_SEND:      if (byte_cnt == LAST_TX) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (alu_done)         state_nxt = ST_RECV;
        else if (timeout_hit) state_nxt = ST_HOLD;
      end
      ST_RECV:      if (alu_done && rx_cnt == LAST_RX) state_nxt = ST_HOLD;
      ST_HOLD:      if (res_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    accept     = cmd_valid && cmd_ready;
    deser_load = alu_done && (state == ST_WAIT_DONE || state == ST_RECV);
    deser_clr  = accept || timeout_hit;
    byte_nxt   = byte_cnt + 3'd1;
  end

  // Operands go out A before B, each LSB first: byte k of {B, A} is driven from edge E(1+k).
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_start  <= 1'b0;
      alu_in     <= '0;
      alu_opcode <= '0;
      tx_word    <= '0;
      byte_cnt   <= '0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          tx_word    <= {cmd_b, cmd_a};
          alu_opcode <= cmd_op;
          alu_start  <= 1'b1;
        end
        ST_START: begin
          alu_start <= 1'b0;
          alu_in    <= tx_word[7:0];
          byte_cnt  <= '0;
        end
        ST_SEND: begin
          if (byte_cnt == LAST_TX) begin
            alu_in <= '0;
          end else begin
            alu_in   <= tx_word[{byte_nxt, 3'b000} +: 8];
            byte_cnt <= byte_nxt;
          end
        end
        ST_WAIT_DONE: if (timeout_hit) res_valid <= 1'b1;
        ST_RECV:      if (alu_done && rx_cnt == LAST_RX) res_valid <= 1'b1;
        ST_HOLD:      if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  fpalu_res_deser u_deser (
    .clk  (clk),
    .rst  (rst),
    .clr  (deser_clr),
    .load (deser_load),
    .din  (alu_out),
    .word (res_data),
    .cnt  (rx_cnt),
    .full (rx_full)
  );

`ifdef FPALU_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  // A done arriving on the expiry edge wins, so the timeout also requires !alu_done.
  assign timeout_hit = (state == ST_WAIT_DONE) && !alu_done &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      res_err <= 1'b0;
    end else begin
      if (state != ST_WAIT_DONE) to_cnt <= '0;
      else if (!alu_done)        to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)
        res_err <= 1'b1;
      else if (state == ST_RECV && alu_done && rx_cnt == LAST_RX)
        res_err <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign res_err        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_fpalu_host_seq.sv
// Bench for fpalu_host_seq: behavioural byte-serial ALU model plus directed vectors.
module tb_fpalu_host_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_in;
  logic [7:0]  alu_out;
  logic        alu_done;

  // ALU model state and stray-done injector
  logic        model_done = 1'b0;
  logic [7:0]  model_out = '0;
  logic        stray_done = 1'b0;
  logic [7:0]  stray_out = '0;
  logic        model_hang = 1'b0;
  logic [31:0] m_res = '0;
  logic [1:0]  m_op = '0;
  logic        op_bad = 1'b0;
  logic [7:0]  m_bytes[8];
  int          m_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  assign alu_done = model_done | stray_done;
  assign alu_out  = stray_done ? stray_out : model_out;

  always #5 clk = ~clk;

  fpalu_host_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_in     (alu_in),
    .alu_out    (alu_out),
    .alu_done   (alu_done)
  );

  // ALU model, evaluated at negedge Nk (between edges Ek and Ek+1):
  // bytes sampled at E2..E9 are visible at N1..N8; done driven N11..N14 for capture at E12..E15.
  always @(negedge clk) begin
    if (rst || (cmd_ready && m_cnt != 0)) begin
      m_cnt      = 0;
      model_done = 1'b0;
      model_out  = '0;
    end else if (m_cnt == 0) begin
      if (alu_start && !model_hang) begin
        m_cnt  = 1;
        op_bad = 1'b0;
      end
    end else begin
      if (alu_opcode !== m_op) op_bad = 1'b1;
      if (m_cnt >= 1 && m_cnt <= 8) m_bytes[m_cnt-1] = alu_in;
      if (m_cnt >= 11 && m_cnt <= 14) begin
        model_done = 1'b1;
        model_out  = m_res[8*(m_cnt-11) +: 8];
      end
      if (m_cnt == 15) begin
        model_done = 1'b0;
        model_out  = '0;
        m_cnt      = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at N0 (negedge after the accept edge).
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] res);
    int guard = 0;
    m_res = res;
    m_op  = op;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("start_n0", 64'(alu_start), 64'd1);
    chk("busy_n0", 64'(cmd_ready), 64'd0);
  endtask

  // Counts negedges from index 'start' until res_valid is seen.
  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (!res_valid && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("start_n1", 64'(alu_start), 64'd0);
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic check_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat, input int exp_lat);
    logic [63:0] got;
    for (int k = 0; k < 8; k++) got[8*k +: 8] = m_bytes[k];
    chk($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s_data", tag), 64'(res_data), 64'(res));
    chk($sformatf("%s_err", tag), 64'(res_err), 64'd0);
    chk($sformatf("%s_bytes", tag), got, {b, a});
    chk($sformatf("%s_op_stable", tag), 64'(op_bad), 64'd0);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 64'(res_valid), 64'd0);
    chk("post_hs_ready", 64'(cmd_ready), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic [63:0] got;
    logic held_ok;
    logic ever_valid;

    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000};  // 1.0 + 2.0
    vecs[1] = '{32'h40A0_0000, 32'h4040_0000, 2'b01, 32'h4000_0000};  // 5.0 - 3.0
    vecs[2] = '{32'h3FC0_0000, 32'h3FC0_0000, 2'b00, 32'h4040_0000};  // 1.5 + 1.5
    vecs[3] = '{32'hC000_0000, 32'h4080_0000, 2'b00, 32'h4000_0000};  // -2.0 + 4.0
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 2'b10, 32'hDEAD_BEEF};  // opcode pass-through

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_alu_start", 64'(alu_start), 64'd0);
    chk("rst_alu_in", 64'(alu_in), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);

    // First vector: explicit operand byte order 00,00,80,3F,00,00,00,40
    send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].res);
    wait_result(0, lat);
    for (int k = 0; k < 8; k++) got[8*k +: 8] = m_bytes[k];
    chk("v0_byte_seq", got, 64'h4000_0000_3F80_0000);
    take_result();

    for (int i = 0; i < 5; i++) begin
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);
      wait_result(0, lat);
      check_txn($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, lat, 15);
      take_result();
    end

    // Backpressure: result held 10 cycles while a second command waits
    res_ready = 1'b0;
    send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].res);
    wait_result(0, lat);
    check_txn("bp_first", vecs[0].a, vecs[0].b, vecs[0].res, lat, 15);
    @(negedge clk);
    m_res = vecs[1].res; m_op = vecs[1].op;
    cmd_a = vecs[1].a; cmd_b = vecs[1].b; cmd_op = vecs[1].op; cmd_valid = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_data !== vecs[0].res || cmd_ready || alu_start) held_ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_held", 64'(held_ok), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 64'(res_valid), 64'd0);
    chk("bp_hs_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_accept", 64'(alu_start), 64'd1);
    wait_result(0, lat);
    check_txn("bp_second", vecs[1].a, vecs[1].b, vecs[1].res, lat, 15);
    take_result();

    // Reset asserted for the single edge E4, mid-SEND
    send_cmd(vecs[1].a, vecs[1].b, vecs[1].op, 32'h0BAD_0BAD);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_alu_start", 64'(alu_start), 64'd0);
    chk("mid_rst_alu_in", 64'(alu_in), 64'd0);
    chk("mid_rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_data", 64'(res_data), 64'd0);
    chk("mid_rst_res_err", 64'(res_err), 64'd0);
    send_cmd(vecs[2].a, vecs[2].b, vecs[2].op, vecs[2].res);
    wait_result(0, lat);
    check_txn("post_rst", vecs[2].a, vecs[2].b, 32'h4040_0000, lat, 15);
    take_result();

    // Gapped done: two bytes, two idle cycles, two bytes
    model_hang = 1'b1;
    send_cmd(32'h0102_0304, 32'h0506_0708, 2'b00, 32'h0);
    repeat (10) @(negedge clk);
    stray_done = 1'b1; stray_out = 8'h44;
    @(negedge clk); stray_out = 8'h33;
    @(negedge clk); stray_done = 1'b0;
    @(negedge clk);
    @(negedge clk); stray_done = 1'b1; stray_out = 8'h22;
    @(negedge clk);
    chk("gap_not_early", 64'(res_valid), 64'd0);
    stray_out = 8'h11;
    @(negedge clk); stray_done = 1'b0;
    chk("gap_valid", 64'(res_valid), 64'd1);
    chk("gap_data", 64'(res_data), 64'h1122_3344);
    chk("gap_err", 64'(res_err), 64'd0);
    take_result();

`ifdef FPALU_SEQ_TIMEOUT_EN
    // Timeout: WAIT_DONE entered at E9, abort 8 edges later at E17
    send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, 32'h0);
    wait_result(0, lat);
    chk("to_latency", 64'(lat), 64'd17);
    chk("to_data", 64'(res_data), 64'd0);
    chk("to_err", 64'(res_err), 64'd1);
    take_result();
`else
    // No timeout: WAIT_DONE must wait, then finish when done finally arrives
    send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, 32'h0);
    ever_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) ever_valid = 1'b1;
    end
    chk("no_to_wait", 64'(ever_valid), 64'd0);
    chk("no_to_err", 64'(res_err), 64'd0);
    stray_done = 1'b1; stray_out = 8'h0D;
    @(negedge clk); stray_out = 8'hF0;
    @(negedge clk); stray_out = 8'hFE;
    @(negedge clk); stray_out = 8'hCA;
    @(negedge clk); stray_done = 1'b0;
    chk("no_to_valid", 64'(res_valid), 64'd1);
    chk("no_to_data", 64'(res_data), 64'hCAFE_F00D);
    take_result();
`endif
    model_hang = 1'b0;

    // Stray done pulses in IDLE and during SEND are ignored
    stray_done = 1'b1; stray_out = 8'hAA;
    @(negedge clk);
    stray_done = 1'b0;
    chk("stray_idle_ready", 64'(cmd_ready), 64'd1);
    chk("stray_idle_valid", 64'(res_valid), 64'd0);
    send_cmd(vecs[3].a, vecs[3].b, vecs[3].op, vecs[3].res);
    repeat (2) @(negedge clk);
    stray_done = 1'b1; stray_out = 8'h55;
    @(negedge clk);
    stray_done = 1'b0;
    wait_result(3, lat);
    check_txn("stray_send", vecs[3].a, vecs[3].b, vecs[3].res, lat, 15);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
